// File: rtl/alu_74181_serial_ctrl.sv
// Nibble-serial sequencer around one 4-bit 74181 ALU: runs WIDTH-bit operations
// LSB nibble first, chaining carries, and returns the result over a valid/ready handshake.
module alu_74181_serial_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [3:0]       op_s,
  input  logic             op_m,
  input  logic             op_cn,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [3:0]       alu_s,
  output logic             alu_m,
  output logic             alu_cn,
  input  logic [3:0]       alu_f,
  input  logic             alu_cn4,
  input  logic             alu_equal,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_f,
  output logic             res_cn,
  output logic             res_equal,
  output logic             busy
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_nx_s;
  logic [WIDTH-1:0] a_r, b_r, shadow_r, shadow_nx_s, res_f_r;
  logic [3:0]       s_r;
  logic             m_r, carry_r, eq_acc_r;
  logic             res_cn_r, res_equal_r;
  logic [IW-1:0]    idx_r, nib_sel_s;
  logic             in_ready_r, out_valid_r, busy_r;
  logic             accept_s, last_s;

  // Next-state decode for the IDLE/RUN/DONE sequencer
  always_comb begin
    state_nx_s = state_r;
    accept_s   = 1'b0;
    last_s     = (idx_r == IW'(NIB - 1));
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready_r) begin
          accept_s   = 1'b1;
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Shadow result with the current nibble merged in; only copied to res_f at completion
  always_comb begin
    shadow_nx_s = shadow_r;
    shadow_nx_s[{idx_r, 2'b00} +: 4] = alu_f;
  end

  // State register and registered handshake flags, derived from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == IDLE);
      out_valid_r <= (state_nx_s == DONE);
      busy_r      <= (state_nx_s != IDLE);
    end
  end

  // Operand capture, per-nibble accumulation and completion result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r         <= {WIDTH{1'b0}};
      b_r         <= {WIDTH{1'b0}};
      s_r         <= 4'd0;
      m_r         <= 1'b0;
      carry_r     <= 1'b1;
      idx_r       <= {IW{1'b0}};
      eq_acc_r    <= 1'b0;
      shadow_r    <= {WIDTH{1'b0}};
      res_f_r     <= {WIDTH{1'b0}};
      res_cn_r    <= 1'b1;
      res_equal_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            a_r      <= op_a;
            b_r      <= op_b;
            s_r      <= op_s;
            m_r      <= op_m;
            carry_r  <= op_cn;
            idx_r    <= {IW{1'b0}};
            eq_acc_r <= 1'b1;
          end
        end
        RUN: begin
          shadow_r <= shadow_nx_s;
          carry_r  <= alu_cn4;
          eq_acc_r <= eq_acc_r & alu_equal;
          if (last_s) begin
            idx_r       <= {IW{1'b0}};
            res_f_r     <= shadow_nx_s;
            res_cn_r    <= alu_cn4;
            res_equal_r <= eq_acc_r & alu_equal;
          end else begin
            idx_r <= idx_r + IW'(1'b1);
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  // Outside RUN the ALU sees nibble 0 of the latched operands
  assign nib_sel_s = (state_r == RUN) ? idx_r : {IW{1'b0}};

  assign alu_a     = a_r[{nib_sel_s, 2'b00} +: 4];
  assign alu_b     = b_r[{nib_sel_s, 2'b00} +: 4];
  assign alu_s     = s_r;
  assign alu_m     = m_r;
  assign alu_cn    = carry_r;

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign res_f     = res_f_r;
  assign res_cn    = res_cn_r;
  assign res_equal = res_equal_r;

endmodule

// File: tb/tb_alu_74181_serial_ctrl.sv
// Scoreboard bench for alu_74181_serial_ctrl: a behavioural 74181 drives the ALU pins,
// expected words come from a whole-word model, a monitor pops and compares on each result handshake.
module tb_alu_74181_serial_ctrl;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  typedef struct {
    logic [W-1:0] f;
    logic         cn;
    logic         eq;
    int           acc_cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] op_a = '0, op_b = '0;
  logic [3:0]   op_s = 4'd0;
  logic         op_m = 1'b0, op_cn = 1'b1;
  logic [3:0]   alu_a, alu_b, alu_s, alu_f;
  logic         alu_m, alu_cn, alu_cn4, alu_equal;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] res_f;
  logic         res_cn, res_equal, busy;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   last_acc = 0;
  logic ov_prev = 1'b0;
  bit   rand_bp = 1'b0;
  exp_t sb[$];

  alu_74181_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cn(op_cn),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cn(alu_cn),
    .alu_f(alu_f), .alu_cn4(alu_cn4), .alu_equal(alu_equal),
    .out_valid(out_valid), .out_ready(out_ready),
    .res_f(res_f), .res_cn(res_cn), .res_equal(res_equal), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // 74181 (active-high data): F is the sum of a select-chosen OR term and AND term plus carry
  function automatic logic [5:0] alu_nib(input logic [3:0] a, input logic [3:0] b,
                                         input logic [3:0] s, input logic m, input logic cn);
    logic [3:0] x, y;
    logic [4:0] sum;
    x   = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
    y   = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
    sum = {1'b0, x} + {1'b0, y} + {4'd0, ~cn};
    return {(a == b), ~sum[4], (m ? ~(x ^ y) : sum[3:0])};
  endfunction

  assign {alu_equal, alu_cn4, alu_f} = alu_nib(alu_a, alu_b, alu_s, alu_m, alu_cn);

  // Whole-word reference: same 74181 function applied to the full operands at once
  function automatic exp_t ref_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [3:0] s, input logic m, input logic cn);
    exp_t e;
    logic [W-1:0] x, y;
    logic [W:0]   sum;
    x   = a | (b & {W{s[0]}}) | (~b & {W{s[1]}});
    y   = (a & b & {W{s[3]}}) | (a & ~b & {W{s[2]}});
    sum = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~cn};
    e.f       = m ? ~(x ^ y) : sum[W-1:0];
    e.cn      = ~sum[W];
    e.eq      = (a == b);
    e.acc_cyc = 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: latency on each out_valid rise, scoreboard pop on each result handshake
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) begin
        if (sb.size() == 0) chk("unexpected_valid", 32'd1, 32'd0);
        else chk("latency", 32'(cyc - sb[0].acc_cyc), 32'(NIB));
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("res_f", 32'(res_f), 32'(e.f));
          chk("res_cn", 32'(res_cn), 32'(e.cn));
          chk("res_equal", 32'(res_equal), 32'(e.eq));
        end
      end
    end
    ov_prev <= out_valid;
  end

  // Random consumer backpressure during the random phase
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                       input logic m, input logic cn, input bit keep);
    exp_t e;
    int n;
    op_a = a; op_b = b; op_s = s; op_m = m; op_cn = cn;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd1, 32'd0);
      in_valid = 1'b0;
      return;
    end
    e = ref_op(a, b, s, m, cn);
    e.acc_cyc = cyc + 1;
    last_acc  = cyc + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      n++;
      @(negedge clk);
    end
    if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc[3];
    int seq[4];
    exp_t e1;
    int h, n;

    // Reset state
    #2 rst_n = 1'b0;
    #10;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res_f", 32'(res_f), 32'd0);
    chk("rst_res_cn", 32'(res_cn), 32'd1);
    chk("rst_res_equal", 32'(res_equal), 32'd0);
    chk("rst_alu_pins", 32'({alu_a, alu_b, alu_s, alu_m, alu_cn}), 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Add
    issue(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b0);
    chk("busy_in_run", 32'(busy), 32'd1);
    chk("in_ready_in_run", 32'(in_ready), 32'd0);
    wait_drain();

    // Carry ripple with per-nibble alu_cn observation
    seq = '{1, 0, 0, 0};
    issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < NIB; i++) begin
      @(negedge clk);
      chk($sformatf("ripple_alu_cn%0d", i), 32'(alu_cn), 32'(seq[i]));
    end
    wait_drain();

    // Logic XOR and equality
    issue(16'hA5A5, 16'h0F0F, 4'b0110, 1'b1, 1'b1, 1'b0);
    wait_drain();
    issue(16'h5A5A, 16'h5A5A, 4'b0110, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Reset mid-operation after two nibbles
    issue(16'h1234, 16'h0FFF, 4'b1001, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_res_f", 32'(res_f), 32'd0);
    chk("mid_rst_res_cn", 32'(res_cn), 32'd1);
    chk("mid_rst_alu_cn", 32'(alu_cn), 32'd1);
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue(16'h8000, 16'h8001, 4'b1001, 1'b0, 1'b0, 1'b0);
    wait_drain();

    // Backpressure: result held, new request ignored until the handshake
    out_ready = 1'b0;
    e1 = ref_op(16'h00F0, 16'h0F10, 4'b1001, 1'b0, 1'b1);
    issue(16'h00F0, 16'h0F10, 4'b1001, 1'b0, 1'b1, 1'b0);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_valid_seen", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1; op_a = 16'h7777; op_b = 16'h1111; op_s = 4'b0110; op_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_res_f_held", 32'(res_f), 32'(e1.f));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    h = cyc + 1;
    issue(16'h7777, 16'h1111, 4'b0110, 1'b0, 1'b1, 1'b0);
    chk("bp_accept_cycle", 32'(last_acc), 32'(h + 1));
    wait_drain();

    // Back-to-back with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      issue(16'($urandom), 16'($urandom), 4'($urandom), 1'b0, 1'($urandom), (i < 2));
      acc[i] = last_acc;
    end
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'(NIB + 2));
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'(NIB + 2));
    wait_drain();

    // Random operations under random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      ra = 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 16'($urandom);
      issue(ra, rb, 4'($urandom), 1'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end
    wait_drain();
    rand_bp = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_74181_serial_ctrl.md
Name: alu_74181_serial_ctrl

Overview:
- Sequencer that time-shares one 4-bit alu_74181 instance to perform WIDTH-bit operations one nibble per clock, LSB nibble first.
- Each nibble's carry-out is chained into the next nibble's carry-in.
- Sits between a valid/ready operand source and the ALU instance; it owns all ALU input pins.
- Returns the WIDTH-bit result, final carry and whole-word equality with a valid/ready result handshake.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 8.
- NIB (local), WIDTH/4, number of nibble passes per operation.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operation request valid.
- in_ready  output  1  controller can accept a request.
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- op_s  input  4  74181 function select.
- op_m  input  1  mode: 1=logic, 0=arithmetic.
- op_cn  input  1  carry-in to nibble 0; 74181 active-high-data convention, 1 = no carry.
- alu_a  output  4  nibble of A driven to ALU.
- alu_b  output  4  nibble of B driven to ALU.
- alu_s  output  4  latched select to ALU.
- alu_m  output  1  latched mode to ALU.
- alu_cn  output  1  carry-in to ALU.
- alu_f  input  4  ALU result (combinational from alu_*).
- alu_cn4  input  1  ALU carry-out; 0 = carry generated.
- alu_equal  input  1  ALU nibble-equality flag.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- res_f  output  WIDTH  result word.
- res_cn  output  1  final carry-out (alu_cn4 of last nibble).
- res_equal  output  1  1 when op_a == op_b across all nibbles.
- busy  output  1  high in RUN or DONE.

Behaviour:
- States: IDLE, RUN, DONE; 2-bit state register.
- Other registers: operand A/B, s, m, carry, nibble index, result, equal accumulator.
- Reset (async, rst_n low) clears all registers immediately, whether idle or mid-operation:
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - res_f=0, res_cn=1, res_equal=0.
  - alu_a=alu_b=alu_s=0, alu_m=0, alu_cn=1.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op_a, op_b, op_s, op_m; carry<=op_cn; idx<=0; equal acc<=1; go to RUN.
- RUN:
  - in_ready=0.
  - ALU pins are driven from registers: alu_a/alu_b = latched nibble[idx], alu_s/alu_m = latched values, alu_cn = carry.
  - Each cycle: result nibble[idx]<=alu_f; carry<=alu_cn4; equal acc<=acc&alu_equal; idx<=idx+1.
  - When idx==NIB-1, that same edge goes to DONE.
- DONE:
  - out_valid=1; res_f, res_cn, res_equal are stable registered values.
  - Hold all outputs while out_ready=0.
  - On out_valid&out_ready: go to IDLE.
- Latency: out_valid rises exactly NIB cycles after the accepting edge.
- Throughput: one operation per NIB+2 cycles. No back-to-back accept in the DONE handshake cycle; in_ready is 1 only in IDLE.
- Carry chain:
  - Same carry logic in logic mode (m=1).
  - res_cn is reported unchanged in logic mode; it is don't-care to consumers.
- idx width: clog2(NIB).
  - idx resets to 0 on every accept.
  - idx is never used outside RUN; ALU pins show nibble 0 of latched operands in IDLE/DONE.
- res_f, res_cn, res_equal update only at RUN→DONE completion. Mid-operation nibble writes are not visible on res_*; an internal shadow result is copied on completion.
- in_valid during RUN/DONE is ignored. op_* may change freely after accept.
- out_ready outside DONE is ignored.

Test Plan:
- Reset: assert rst_n=0 mid-RUN (after 2 nibbles of an add) -> same cycle state=IDLE, out_valid=0, in_ready=1, res_f=0x0000, res_cn=1; next accepted op completes correctly.
- Add (WIDTH=16): A=0x1234, B=0x0FFF, s=1001, m=0, cn=1 -> out_valid exactly 4 cycles after accept, res_f=0x2233, res_cn=1, res_equal=0.
- Carry ripple: A=0xFFFF, B=0x0001, s=1001, m=0, cn=1 -> res_f=0x0000, res_cn=0; alu_cn sequence observed 1,0,0,0 across RUN cycles.
- Logic/equality: m=1, s=0110, A=0xA5A5, B=0x0F0F -> res_f=0xAAAA, res_equal=0; then A=B=0x5A5A -> res_equal=1.
- Backpressure: complete an op, then out_ready=0 for 3 cycles with in_valid=1 and new operands -> out_valid and res_* held, in_ready=0, no accept; raise out_ready -> IDLE next cycle, in_ready=1, new op accepted.
- Back-to-back: in_valid held high and out_ready held high for 3 ops -> each op takes 6 cycles accept-to-accept, results match a reference model.
